datamem_arbiter: RTL and testbench
==================================

Name: datamem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the 64-word DataMemory (6-bit word address, synchronous write, read data valid after the clock edge that samples MemoryRead).
- Port 0 is the CPU load/store unit; port 1 is the test/DMA loader.
- Each port uses a request/done handshake. The block grants one access at a time, round-robin, and drives the DataMemory strobes from registers.
- Byte-address checking is done here, so the memory never sees an illegal address.

Parameters:
- ADDR_W, 6, DataMemory word-address width (64 words).
- DATA_W, 32, data width.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_L  in  1  asynchronous, active-low reset.
- Req0, Req1  in  1 each  access request; level, held until the matching Done.
- Write0, Write1  in  1 each  1 = write, 0 = read; stable while Req is high.
- Addr0, Addr1  in  32 each  byte address; stable while Req is high.
- WData0, WData1  in  DATA_W each  write data; stable while Req is high.
- Done0, Done1  out  1 each  one-cycle completion pulse.
- Err0, Err1  out  1 each  high with Done when the access was rejected.
- RData0, RData1  out  DATA_W each  read data; valid only while the matching Done is high after a read.
- MemAddress  out  ADDR_W  to DataMemory Address.
- MemWriteData  out  DATA_W  to DataMemory WriteData.
- MemoryRead  out  1  to DataMemory.
- MemoryWrite  out  1  to DataMemory.
- MemReadData  in  DATA_W  from DataMemory ReadData.

Behaviour:
- Reset (async, Reset_L=0):
  - State=IDLE, LastGnt=1 (port 0 favoured first).
  - MemoryRead=MemoryWrite=0, MemAddress=0, MemWriteData=0.
  - Done*=0, Err*=0, RData*=0.
  - All outputs are registered and clear immediately, without waiting for a clock edge.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port != LastGnt (round-robin).
  - On grant, register Gnt, Addr[7:2] -> MemAddress, WData -> MemWriteData; set LastGnt=Gnt.
  - Legal address: raise MemoryWrite (write) or MemoryRead (read) and go to ISSUE.
  - Illegal address: no strobe; go to RESP with error flag set.
- Legal address: Addr[1:0]==0 and Addr[31:8]==0.
- ISSUE:
  - Strobes are high for exactly this one cycle; the memory samples at the end of the cycle.
  - Next state RESP; strobes drop to 0.
- RESP:
  - DoneGnt=1 for one cycle; ErrGnt=error flag.
  - On a read, RDataGnt=MemReadData, passed through combinationally, gated by Done.
  - Next state IDLE.
- Latency: grant edge -> Done is 2 cycles for legal accesses and 1 cycle for errors.
- Throughput: one legal access per 3 cycles.
- The non-granted port's Done, Err and RData stay 0.
- A requester may keep Req high after Done for a new access. It is re-arbitrated in IDLE the following cycle, and round-robin gives the other port priority if it is waiting.
- Protocol violation (Req dropped before Done): the access still completes and Done still pulses.
- Reset mid-ISSUE: strobes clear asynchronously. The write is aborted if reset is asserted before the sampling edge; no Done is produced.
- Memory contents are not cleared by this block.

Optional Feature:
- Macro DATAMEM_ARB_FIXED_PRIORITY_EN.
- Defined: port 0 always wins simultaneous requests and LastGnt is unused. Port 1 may starve; this mode is intended for CPU-dominant runs.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), ADDR_W/DATA_W defaults, and the address legality mask constant (32'hFFFF_FF03).
- One sub-module, datamem_arb_pick: combinational grant logic (Req0, Req1, LastGnt -> Gnt, Valid), including the fixed-priority macro branch.
- The FSM and datapath registers live in the top module.

Test Plan:
1. Port 0 writes 32'h4 to 0x0, then reads 0x0 -> write Done0 at +2 cycles; read Done0 with RData0=32'h4, Err0=0.
2. Port 1 writes 0xf0=32'hffff0000 and 0xcc=32'd1431699200; port 0 reads both -> RData0 matches both values, Done1/RData1 never assert during port 0 reads.
3. Req0 and Req1 held high together (port 0 reads 0xc, port 1 reads 0xc8 after preload 40 / 32'haaaaffff) -> grants alternate 0,1,0,1 and each RData is correct.
4. Port 0 reads 0x102 and writes 0x100 -> Done0=Err0=1 one cycle after grant; MemoryRead/MemoryWrite never rise; the later read of 0x0 is unchanged.
5. Reset_L pulled low during the ISSUE of a write of 32'h55 to 0x14 (memory previously 0) -> strobes drop immediately, no Done, state IDLE; a read of 0x14 after reset returns 0.
6. With DATAMEM_ARB_FIXED_PRIORITY_EN defined, both ports requesting continuously -> port 0 is granted every arbitration and Done1 never pulses until Req0 drops.

Source files
------------

// File: rtl/datamem_arbiter_pkg.sv
// Shared types and constants for the two-port DataMemory arbiter.
// Used by datamem_arbiter and datamem_arb_pick.
package datamem_arbiter_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  // Any address bit set under this mask is rejected:
  // the two byte-offset bits and everything above the 64-word window.
  localparam logic [31:0] ADDR_ILLEGAL_MASK = 32'hFFFF_FF03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr & ADDR_ILLEGAL_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/datamem_arb_pick.sv
// Combinational grant selection for the two request ports.
// DATAMEM_ARB_FIXED_PRIORITY_EN: port 0 always wins and last_gnt is ignored.
module datamem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
`ifdef DATAMEM_ARB_FIXED_PRIORITY_EN
    gnt = ~req0;
`else
    if (req0 && req1) begin
      gnt = ~last_gnt;
    end else begin
      gnt = ~req0;
    end
`endif
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port request/done sequencer in front of the 64-word DataMemory.
// Arbitration is round-robin unless DATAMEM_ARB_FIXED_PRIORITY_EN is defined.
module datamem_arbiter
  import datamem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Write0,
  input  logic              Write1,
  input  logic [31:0]       Addr0,
  input  logic [31:0]       Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Done0,
  output logic              Done1,
  output logic              Err0,
  output logic              Err1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemoryRead,
  output logic              MemoryWrite,
  input  logic [DATA_W-1:0] MemReadData
);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic              pick_gnt;
  logic              pick_valid;
  logic              sel_write;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;

  datamem_arb_pick u_pick (
    .req0     (Req0),
    .req1     (Req1),
    .last_gnt (last_gnt_q),
    .gnt      (pick_gnt),
    .valid    (pick_valid)
  );

  assign sel_write = pick_gnt ? Write1 : Write0;
  assign sel_addr  = pick_gnt ? Addr1  : Addr0;
  assign sel_wdata = pick_gnt ? WData1 : WData0;
  assign sel_legal = addr_legal(sel_addr);

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      is_write_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      is_write_q  <= is_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Rejected accesses skip ISSUE so the memory never sees a strobe for them.
  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = sel_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    is_write_d  = is_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_d      = 2'b00;
    err_d       = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d       = pick_gnt;
          last_gnt_d  = pick_gnt;
          is_write_d  = sel_write;
          mem_addr_d  = sel_addr[ADDR_W+1:2];
          mem_wdata_d = sel_wdata;
          if (sel_legal) begin
            mem_wr_d = sel_write;
            mem_rd_d = ~sel_write;
          end else begin
            done_d[pick_gnt] = 1'b1;
            err_d[pick_gnt]  = 1'b1;
          end
        end
      end
      ST_ISSUE: done_d[gnt_q] = 1'b1;
      default: ;
    endcase
  end

  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  assign MemoryRead   = mem_rd_q;
  assign MemoryWrite  = mem_wr_q;
  assign Done0        = done_q[0];
  assign Done1        = done_q[1];
  assign Err0         = err_q[0];
  assign Err1         = err_q[1];

  // Memory read data is only meaningful in the RESP cycle of a successful read.
  assign RData0 = (done_q[0] && !err_q[0] && !is_write_q) ? MemReadData : '0;
  assign RData1 = (done_q[1] && !err_q[1] && !is_write_q) ? MemReadData : '0;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed self-checking bench for datamem_arbiter with a behavioural 64-word DataMemory.
module tb_datamem_arbiter;
  import datamem_arbiter_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_L = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic        Write0 = 1'b0, Write1 = 1'b0;
  logic [31:0] Addr0 = '0, Addr1 = '0;
  logic [31:0] WData0 = '0, WData1 = '0;
  logic        Done0, Done1, Err0, Err1;
  logic [31:0] RData0, RData1;
  logic [5:0]  MemAddress;
  logic [31:0] MemWriteData;
  logic        MemoryRead, MemoryWrite;
  logic [31:0] MemReadData;

  logic [31:0] mem [64];
  logic        clr_mem = 1'b1;
  int          checks = 0;
  int          errors = 0;

  datamem_arbiter dut (
    .Clock        (Clock),
    .Reset_L      (Reset_L),
    .Req0         (Req0),
    .Req1         (Req1),
    .Write0       (Write0),
    .Write1       (Write1),
    .Addr0        (Addr0),
    .Addr1        (Addr1),
    .WData0       (WData0),
    .WData1       (WData1),
    .Done0        (Done0),
    .Done1        (Done1),
    .Err0         (Err0),
    .Err1         (Err1),
    .RData0       (RData0),
    .RData1       (RData1),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemoryRead   (MemoryRead),
    .MemoryWrite  (MemoryWrite),
    .MemReadData  (MemReadData)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      MemReadData <= '0;
    end else begin
      if (MemoryWrite) mem[MemAddress] <= MemWriteData;
      if (MemoryRead)  MemReadData <= mem[MemAddress];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Single uncontended access; caller starts at a negedge with the arbiter idle.
  task automatic access(input int port, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, input string tag);
    int   cyc;
    logic seen, strobe, other;
    cyc = 0; seen = 0; strobe = 0; other = 0;
    if (port == 0) begin
      Write0 = wr; Addr0 = addr; WData0 = wdata; Req0 = 1'b1;
    end else begin
      Write1 = wr; Addr1 = addr; WData1 = wdata; Req1 = 1'b1;
    end
    while (!seen && cyc < 20) begin
      @(posedge Clock); #1;
      cyc++;
      if (MemoryRead || MemoryWrite) strobe = 1'b1;
      if ((port == 0) ? Done1 : Done0) other = 1'b1;
      if ((port == 0) ? Done0 : Done1) begin
        seen = 1'b1;
        check({tag, "_err"}, 32'((port == 0) ? Err0 : Err1), 32'(exp_err));
        if (!wr && !exp_err)
          check({tag, "_rdata"}, (port == 0) ? RData0 : RData1, exp_rdata);
        check({tag, "_other_rdata"}, (port == 0) ? RData1 : RData0, 32'h0);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'h1);
    check({tag, "_latency"}, cyc, exp_err ? 1 : 2);
    check({tag, "_strobe"}, 32'(strobe), 32'(!exp_err));
    check({tag, "_other_done"}, 32'(other), 32'h0);
    $display("txn %s port=%0d wr=%0d addr=%h wdata=%h cycles=%0d", tag, port, wr, addr, wdata, cyc);
    @(negedge Clock);
    if (port == 0) Req0 = 1'b0; else Req1 = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    int n, cyc, got_port, exp_port;
    logic seen, strobe;

    // Reset state, held across clock edges.
    repeat (2) @(posedge Clock);
    #1;
    check("rst_done", {30'h0, Done1, Done0}, 32'h0);
    check("rst_err", {30'h0, Err1, Err0}, 32'h0);
    check("rst_rdata0", RData0, 32'h0);
    check("rst_rdata1", RData1, 32'h0);
    check("rst_strobes", {30'h0, MemoryRead, MemoryWrite}, 32'h0);
    check("rst_maddr", 32'(MemAddress), 32'h0);
    check("rst_mwdata", MemWriteData, 32'h0);
    @(negedge Clock);
    Reset_L = 1'b1;
    clr_mem = 1'b0;
    @(negedge Clock);

    // 1: port 0 write then read back.
    access(0, 1'b1, 32'h0, 32'h4, 1'b0, 32'h0, "t1_wr");
    access(0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, "t1_rd");

    // 2: port 1 writes, port 0 reads.
    access(1, 1'b1, 32'hf0, 32'hffff0000, 1'b0, 32'h0, "t2_wr_f0");
    access(1, 1'b1, 32'hcc, 32'd1431699200, 1'b0, 32'h0, "t2_wr_cc");
    access(0, 1'b0, 32'hf0, 32'h0, 1'b0, 32'hffff0000, "t2_rd_f0");
    access(0, 1'b0, 32'hcc, 32'h0, 1'b0, 32'd1431699200, "t2_rd_cc");

    // 3/6: preload, ending with a port-1 access so port 0 is favoured next.
    access(0, 1'b1, 32'hc, 32'd40, 1'b0, 32'h0, "t3_pre_c");
    access(1, 1'b1, 32'hc8, 32'haaaaffff, 1'b0, 32'h0, "t3_pre_c8");
    Write0 = 1'b0; Addr0 = 32'hc; Write1 = 1'b0; Addr1 = 32'hc8;
    Req0 = 1'b1; Req1 = 1'b1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(posedge Clock); #1;
      cyc++;
      if (Done0 || Done1) begin
        check("both_done_once", {30'h0, Done1, Done0} & 32'h3, Done1 ? 32'h2 : 32'h1);
        got_port = Done1 ? 1 : 0;
`ifdef DATAMEM_ARB_FIXED_PRIORITY_EN
        exp_port = 0;
`else
        exp_port = n % 2;
`endif
        check("both_grant_port", got_port, exp_port);
        check("both_rdata", got_port ? RData1 : RData0, got_port ? 32'haaaaffff : 32'd40);
        $display("txn both n=%0d port=%0d rdata=%h", n, got_port, got_port ? RData1 : RData0);
        n++;
      end
    end
    check("both_count", n, 4);
    @(negedge Clock);
    Req0 = 1'b0;
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(posedge Clock); #1;
      cyc++;
      if (Done1) begin
        seen = 1'b1;
        check("after_drop_rdata1", RData1, 32'haaaaffff);
      end
    end
    check("after_drop_done1", 32'(seen), 32'h1);
    @(negedge Clock);
    Req1 = 1'b0;
    @(negedge Clock);

    // 4: illegal addresses, then confirm word 0 untouched.
    access(0, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, "t4_rd_102");
    access(0, 1'b1, 32'h100, 32'hdeadbeef, 1'b1, 32'h0, "t4_wr_100");
    access(0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, "t4_rd_0");

    // 5: reset asserted in the middle of the ISSUE cycle of a write.
    Write0 = 1'b1; Addr0 = 32'h14; WData0 = 32'h55; Req0 = 1'b1;
    strobe = 0; cyc = 0;
    while (!strobe && cyc < 10) begin
      @(posedge Clock); #1;
      cyc++;
      if (MemoryWrite) strobe = 1'b1;
    end
    check("t5_issue_seen", 32'(strobe), 32'h1);
    Reset_L = 1'b0;
    #1;
    check("t5_strobes_cleared", {30'h0, MemoryRead, MemoryWrite}, 32'h0);
    check("t5_no_done", {30'h0, Done1, Done0}, 32'h0);
    check("t5_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge Clock);
    Req0 = 1'b0;
    @(posedge Clock); #1;
    check("t5_no_done_held", {30'h0, Done1, Done0}, 32'h0);
    @(negedge Clock);
    Reset_L = 1'b1;
    @(negedge Clock);
    access(0, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, "t5_rd_14");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
